// File: rtl/tp_addr_gen.sv
// Transpose-buffer address generator: one read row per cycle (natural or skewed), write issued BTF_LAT cycles later into the opposite half.
// First rd_en the cycle after start; stall freezes FSM, counters and write pipe, and forces rd_en/wr_en low.
module tp_addr_gen #(
    parameter  int TP      = 8,
    parameter  int SIZE    = 64,
    parameter  int BTF_LAT = 8,
    parameter  int MAXBLK  = 16,
    localparam int ROWS    = SIZE / TP,
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int AW      = RW + 1,
    localparam int TPW     = $clog2(TP),
    localparam int BW      = $clog2(MAXBLK) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BW-1:0]    num_blk,
    input  logic             mode,
    input  logic             stall,
    output logic             rd_en,
    output logic [TP*AW-1:0] rd_addr,
    output logic [TPW-1:0]   rd_rot,
    output logic             wr_en,
    output logic [TP*AW-1:0] wr_addr,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t             state_q, state_d;
    logic [RW-1:0]      row_q, row_d;
    logic [BW-1:0]      blk_q, blk_d, nblk_q, nblk_d;
    logic               mode_q, mode_d;
    logic [BTF_LAT-1:0] pv_q, pv_d;
    logic [AW-1:0]      pa_q [BTF_LAT];
    logic [AW-1:0]      pa_d [BTF_LAT];
    logic               rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [TP*AW-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [TPW-1:0]     rd_rot_q, rd_rot_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic               accept, issue, last, pp, cur_mode;
    logic [RW-1:0]      cur_row;
    logic [BW-1:0]      cur_blk, cur_nblk, nb_clamp;
    int                 lane;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        blk_d     = blk_q;
        nblk_d    = nblk_q;
        mode_d    = mode_q;
        pv_d      = pv_q;
        pa_d      = pa_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_rot_d  = rd_rot_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        lane      = 0;

        nb_clamp = (num_blk > BW'(MAXBLK)) ? BW'(MAXBLK) : num_blk;
        accept   = (state_q == S_IDLE) && start;
        // On the accepting edge row 0 of block 0 is issued straight from the inputs.
        cur_row  = accept ? '0 : row_q;
        cur_blk  = accept ? '0 : blk_q;
        cur_nblk = accept ? nb_clamp : nblk_q;
        cur_mode = accept ? mode : mode_q;
        pp       = cur_blk[0];
        issue    = !stall && ((accept && (nb_clamp != '0)) || (state_q == S_RUN));
        last     = (cur_row == RW'(ROWS - 1)) && (cur_blk == cur_nblk - BW'(1));

        if (accept) begin
            nblk_d = nb_clamp;
            mode_d = mode;
            row_d  = '0;
            blk_d  = '0;
        end

        if (issue) begin
            row_d    = (cur_row == RW'(ROWS - 1)) ? '0 : cur_row + RW'(1);
            blk_d    = (cur_row == RW'(ROWS - 1)) ? cur_blk + BW'(1) : cur_blk;
            rd_en_d  = 1'b1;
            rd_rot_d = cur_mode ? TPW'(int'(cur_row) % TP) : '0;
            for (int k = 0; k < TP; k++) begin
                lane = (k + TP - (int'(cur_row) % TP)) % TP;
                rd_addr_d[k*AW +: AW] = cur_mode ? {pp, RW'(lane % ROWS)} : {pp, cur_row};
            end
        end

        if (!stall) begin
            pv_d    = BTF_LAT'({pv_q, issue});
            pa_d[0] = {~pp, cur_row};
            for (int k = 1; k < BTF_LAT; k++) pa_d[k] = pa_q[k-1];
            wr_en_d = pv_q[BTF_LAT-1];
            if (pv_q[BTF_LAT-1]) wr_addr_d = {TP{pa_q[BTF_LAT-1]}};
        end

        case (state_q)
            S_IDLE:  if (start) state_d = (nb_clamp == '0) ? S_FIN : S_RUN;
            S_RUN:   state_d = S_RUN;
            S_DRAIN: if (!stall && (pv_q == '0)) state_d = S_FIN;
            default: state_d = S_IDLE;  // done is a single-cycle pulse, even under stall
        endcase
        if (issue && last) state_d = S_DRAIN;

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            blk_q     <= '0;
            nblk_q    <= '0;
            mode_q    <= 1'b0;
            pv_q      <= '0;
            for (int k = 0; k < BTF_LAT; k++) pa_q[k] <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_rot_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            blk_q     <= blk_d;
            nblk_q    <= nblk_d;
            mode_q    <= mode_d;
            pv_q      <= pv_d;
            for (int k = 0; k < BTF_LAT; k++) pa_q[k] <= pa_d[k];
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_rot_q  <= rd_rot_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign rd_rot  = rd_rot_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_tp_addr_gen.sv
// Bench for tp_addr_gen: job-timeline reference model checked every cycle, plus directed literal pins and a small TP=4 instance.
module tb_tp_addr_gen;
    localparam int TP = 8, SIZE = 64, L = 8, MAXBLK = 16;
    localparam int ROWS = SIZE / TP, RW = 3, AW = 4, BW = 5;

    logic clk = 0, rst = 1;
    logic start = 0, mode = 0, stall = 0;
    logic [BW-1:0] num_blk = '0;
    logic rd_en, wr_en, busy, done;
    logic [TP*AW-1:0] rd_addr, wr_addr;
    logic [2:0] rd_rot;

    logic start2 = 0, mode2 = 0;
    logic [4:0] num_blk2 = '0;
    logic rd_en2, wr_en2, busy2, done2;
    logic [7:0] rd_addr2, wr_addr2;
    logic [1:0] rd_rot2;

    int errs = 0, checks = 0, cyc = 0, t0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tp_addr_gen #(.TP(TP), .SIZE(SIZE), .BTF_LAT(L), .MAXBLK(MAXBLK)) dut (
        .clk(clk), .rst(rst), .start(start), .num_blk(num_blk), .mode(mode), .stall(stall),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_rot(rd_rot), .wr_en(wr_en), .wr_addr(wr_addr),
        .busy(busy), .done(done));

    tp_addr_gen #(.TP(4), .SIZE(8), .BTF_LAT(2), .MAXBLK(16)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .num_blk(num_blk2), .mode(mode2), .stall(1'b0),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_rot(rd_rot2), .wr_en(wr_en2), .wr_addr(wr_addr2),
        .busy(busy2), .done(done2));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected read vector for the item-th row of a job: lane i of row r lands in bank (i+r)%TP when skewed.
    function automatic logic [TP*AW-1:0] exp_rd(input int item, input bit md);
        logic [TP*AW-1:0] v;
        int r, b;
        logic pp;
        r = item % ROWS;
        b = item / ROWS;
        pp = (b % 2) == 1;
        v = '0;
        for (int i = 0; i < TP; i++) begin
            if (md) v[((i + r) % TP)*AW +: AW] = {pp, RW'(i % ROWS)};
            else    v[i*AW +: AW] = {pp, RW'(r)};
        end
        return v;
    endfunction

    function automatic logic [TP*AW-1:0] exp_wr(input int item);
        logic pp;
        pp = ((item / ROWS) % 2) == 1;
        return {TP{~pp, RW'(item % ROWS)}};
    endfunction

    // Reference model: a job is a timeline over non-stalled cycles tau; row j is read at tau=j+1,
    // written at tau=j+1+L, and done follows at tau=N+L+1.
    logic e_rd_en = 0, e_wr_en = 0, e_busy = 0, e_done = 0;
    logic [TP*AW-1:0] e_rd_addr = '0, e_wr_addr = '0;
    logic [2:0] e_rd_rot = '0;
    bit active = 0, m_mode = 0, was_fin = 0;
    int tau = 0, n_items = 0, nb = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            active = 0; e_rd_en = 0; e_wr_en = 0; e_busy = 0; e_done = 0;
            e_rd_addr = '0; e_wr_addr = '0; e_rd_rot = '0;
        end else begin
            was_fin = e_done;
            e_rd_en = 0; e_wr_en = 0; e_done = 0;
            if (!active && start && !was_fin) begin
                nb = (int'(num_blk) > MAXBLK) ? MAXBLK : int'(num_blk);
                if (nb == 0) e_done = 1;
                else begin
                    active = 1; n_items = nb * ROWS; m_mode = mode; tau = 0;
                end
            end
            if (active && !stall) begin
                tau++;
                if (tau <= n_items) begin
                    e_rd_en = 1;
                    e_rd_addr = exp_rd(tau - 1, m_mode);
                    e_rd_rot = m_mode ? 3'((tau - 1) % ROWS % TP) : 3'd0;
                end
                if (tau > L && tau <= L + n_items) begin
                    e_wr_en = 1;
                    e_wr_addr = exp_wr(tau - L - 1);
                end
                if (tau == n_items + L + 1) begin
                    e_done = 1;
                    active = 0;
                end
            end
            e_busy = active;
        end
    end

    always @(negedge clk) begin
        check("rd_en", 64'(rd_en), 64'(e_rd_en));
        check("rd_addr", 64'(rd_addr), 64'(e_rd_addr));
        check("rd_rot", 64'(rd_rot), 64'(e_rd_rot));
        check("wr_en", 64'(wr_en), 64'(e_wr_en));
        check("wr_addr", 64'(wr_addr), 64'(e_wr_addr));
        check("busy", 64'(busy), 64'(e_busy));
        check("done", 64'(done), 64'(e_done));
    end

    task automatic start_job(input int n, input bit md);
        @(posedge clk); #1;
        start = 1; num_blk = BW'(n); mode = md; t0 = cyc;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic goto_t(input int k);
        while (cyc < t0 + k) begin @(posedge clk); #1; end
    endtask

    task automatic at_t(input int k);
        goto_t(k);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 600) begin @(posedge clk); #1; n++; end
        check("idle_timeout", 64'(n < 600), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        @(posedge clk); #1; rst = 0;

        // Natural single block.
        start_job(1, 0);
        at_t(1); check("t1_rd", 64'(rd_addr), 64'h0000_0000); check("t1_rd_en", 64'(rd_en), 64'd1);
        at_t(2); check("t2_rd", 64'(rd_addr), 64'h1111_1111);
        at_t(9); check("t9_wr", 64'(wr_addr), 64'h8888_8888); check("t9_wr_en", 64'(wr_en), 64'd1);
        at_t(17); check("t17_done", 64'(done), 64'd1); check("t17_busy", 64'(busy), 64'd0);
        wait_idle();

        // Skewed, two blocks.
        start_job(2, 1);
        at_t(4); check("sk_r3_b0", 64'(rd_addr), 64'h4321_0765); check("sk_rot3", 64'(rd_rot), 64'd3);
        at_t(12); check("sk_r3_b1", 64'(rd_addr), 64'hCBA9_8FED); check("sk_wr_b0", 64'(wr_addr), 64'hBBBB_BBBB);
        at_t(20); check("sk_wr_b1", 64'(wr_addr), 64'h3333_3333);
        at_t(25); check("sk_done", 64'(done), 64'd1);
        wait_idle();

        // Three-cycle stall mid-run.
        start_job(1, 0);
        goto_t(3); stall = 1;
        repeat (3) @(posedge clk);
        #1; stall = 0;
        at_t(7); check("stall_resume", 64'(rd_addr), 64'h3333_3333);
        at_t(17); check("stall_no_done", 64'(done), 64'd0);
        at_t(20); check("stall_done", 64'(done), 64'd1);
        wait_idle();

        // Empty job, then a start pulse while busy.
        start_job(0, 0);
        at_t(1); check("nb0_done", 64'(done), 64'd1); check("nb0_rd_en", 64'(rd_en), 64'd0);
        wait_idle();
        start_job(1, 0);
        goto_t(3); start = 1; num_blk = 5'd2; mode = 1;
        @(posedge clk); #1; start = 0;
        at_t(17); check("busy_start_done", 64'(done), 64'd1);
        at_t(18); check("busy_start_idle", 64'(busy), 64'd0);
        wait_idle();

        // Reset during drain.
        start_job(1, 0);
        goto_t(12); rst = 1;
        @(negedge clk);
        check("rst_drain_wr", 64'(wr_en), 64'd0); check("rst_drain_busy", 64'(busy), 64'd0);
        @(posedge clk); #1; rst = 0;
        repeat (8) @(posedge clk);
        #1;
        start_job(1, 1);
        at_t(17); check("post_rst_done", 64'(done), 64'd1);
        wait_idle();

        // TP=4, SIZE=8, BTF_LAT=2 instance, skewed, two blocks.
        @(posedge clk); #1;
        start2 = 1; num_blk2 = 5'd2; mode2 = 1; t0 = cyc;
        @(posedge clk); #1; start2 = 0;
        at_t(1); check("p4_r0", 64'(rd_addr2), 64'h44); check("p4_rot0", 64'(rd_rot2), 64'd0);
        at_t(2); check("p4_r1", 64'(rd_addr2), 64'h11); check("p4_rot1", 64'(rd_rot2), 64'd1);
        at_t(3); check("p4_b1r0", 64'(rd_addr2), 64'hEE); check("p4_wr0", 64'(wr_addr2), 64'hAA);
        at_t(4); check("p4_b1r1", 64'(rd_addr2), 64'hBB); check("p4_rot1b", 64'(rd_rot2), 64'd1);
        at_t(7); check("p4_done", 64'(done2), 64'd1);
        @(posedge clk); #1;

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst     = ($urandom_range(0, 399) == 0);
            stall   = ($urandom_range(0, 4) == 0);
            start   = ($urandom_range(0, 5) == 0);
            num_blk = BW'($urandom_range(0, 20));
            mode    = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        rst = 0; stall = 0; start = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
